// File: rtl/result_byte_sequencer_pkg.sv
// result_byte_sequencer_pkg: shared state encoding, select constants and data width
// for the result byte sequencer and its helpers.
package result_byte_sequencer_pkg;

  localparam int BYTE_W = 8;

  // Walk order: MSB byte (ch_0) first, LSB byte (ch_3) last.
  localparam logic [1:0] SEL_FIRST = 2'b11;
  localparam logic [1:0] SEL_LAST  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_CKSUM = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/result_byte_gap_timer.sv
// result_byte_gap_timer: loadable down-counter with a zero flag, used to pace
// output bytes. Load has priority over decrement; the count parks at zero.
module result_byte_gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Counter register: load wins, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/result_byte_sequencer.sv
// result_byte_sequencer: walks the 4x1 result mux from MSB to LSB byte and
// forwards each byte to a valid/ready sink, one transfer per accepted start.
// Optional checksum byte: define RESULT_BYTE_SEQ_CHECKSUM_EN to append the XOR
// of the four data bytes as a fifth byte.
//
// state | meaning
// IDLE  | sel parked at MSB, waiting for start
// FETCH | capture byte_in for the current sel, raise tx_valid
// SEND  | hold tx_valid/tx_data until the sink accepts
// GAP   | idle pacing cycles between accepted bytes
// CKSUM | present the XOR checksum byte until accepted (feature build only)
// FIN   | one-cycle done pulse, drop busy, re-park sel
module result_byte_sequencer
  import result_byte_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [1:0]        sel,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t            state, state_nxt;
  logic [1:0]        sel_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic              tx_valid_nxt, busy_nxt, done_nxt;
  logic              gap_load, gap_dec, gap_zero;
  logic              hs;

`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] acc, acc_nxt;
  logic              cks_pend, cks_pend_nxt;
`endif

  assign hs = tx_valid && tx_ready;

  result_byte_gap_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
    acc_nxt      = acc;
    cks_pend_nxt = cks_pend;
`endif
    case (state)
      ST_IDLE: begin
        sel_nxt = SEL_FIRST;
        if (start) begin
          state_nxt = ST_FETCH;
          busy_nxt  = 1'b1;
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
          acc_nxt      = '0;
          cks_pend_nxt = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        tx_data_nxt  = byte_in;
        tx_valid_nxt = 1'b1;
        state_nxt    = ST_SEND;
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
        acc_nxt = acc ^ byte_in;
`endif
      end
      ST_SEND: begin
        if (hs) begin
          tx_valid_nxt = 1'b0;
          if (sel != SEL_LAST) begin
            sel_nxt = sel - 2'd1;
            if (GAP_CYCLES > 0) begin
              state_nxt = ST_GAP;
              gap_load  = 1'b1;
            end else begin
              state_nxt = ST_FETCH;
            end
          end else begin
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
            // The GAP after the last data byte must know to exit to CKSUM.
            cks_pend_nxt = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_nxt = ST_GAP;
              gap_load  = 1'b1;
            end else begin
              state_nxt    = ST_CKSUM;
              tx_data_nxt  = acc;
              tx_valid_nxt = 1'b1;
            end
`else
            state_nxt = ST_FIN;
`endif
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
          if (cks_pend) begin
            state_nxt    = ST_CKSUM;
            tx_data_nxt  = acc;
            tx_valid_nxt = 1'b1;
          end else begin
            state_nxt = ST_FETCH;
          end
`else
          state_nxt = ST_FETCH;
`endif
        end else begin
          gap_dec = 1'b1;
        end
      end
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
      ST_CKSUM: begin
        if (hs) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        busy_nxt  = 1'b0;
        sel_nxt   = SEL_FIRST;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    done_nxt = (state_nxt == ST_FIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= SEL_FIRST;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
  // Checksum accumulator and pending-checksum flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cks_pend <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      cks_pend <= cks_pend_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_result_byte_sequencer.sv
// tb_result_byte_sequencer: two instances (no gap, 3-cycle gap) driven from one
// process; a transfer-level model checks byte order, stalls, gaps, busy and done.
module tb_result_byte_sequencer;

  localparam int GAP_B = 3;
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_start [2];
  logic       s_ready [2];
  logic [1:0] s_sel   [2];
  logic [7:0] s_byte  [2];
  logic [7:0] s_data  [2];
  logic       s_valid [2];
  logic       s_busy  [2];
  logic       s_done  [2];
  logic [7:0] ch      [4];

  always #5 clk = ~clk;

  // Result mux model: sel 11 -> ch[0] ... sel 00 -> ch[3].
  always_comb begin
    for (int g = 0; g < 2; g++) s_byte[g] = ch[~s_sel[g]];
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    result_byte_sequencer #(.GAP_CYCLES(g == 0 ? 0 : GAP_B), .GAP_W(8)) dut (
      .clk(clk), .rst(rst), .start(s_start[g]), .sel(s_sel[g]), .byte_in(s_byte[g]),
      .tx_data(s_data[g]), .tx_valid(s_valid[g]), .tx_ready(s_ready[g]),
      .busy(s_busy[g]), .done(s_done[g]));
  end

  int n_cmp, n_err;

  bit         active [2];
  bit         done_due [2];
  bit         prev_stall [2];
  bit         prev_tv [2];
  logic [7:0] prev_data [2];
  int         idx [2];
  int         zrun [2];
  int         n_done [2];
  logic [7:0] expb [2][5];

  typedef struct {
    logic       start;
    logic       ready;
    logic [1:0] sel;
    logic       tv;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t vec [13];
  int   nvec;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic string nm(input int g, input string s);
    return $sformatf("dut%0d_%s", g, s);
  endfunction

  function automatic int gap_of(input int g);
    return (g == 0) ? 0 : GAP_B;
  endfunction

  // Transfer-level reference: called mid-cycle, after this cycle's inputs are set.
  task automatic monitor();
    bit was, dd, hs;
    int ez, es;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        active[g] = 0; idx[g] = 0; done_due[g] = 0;
        prev_stall[g] = 0; prev_tv[g] = 0; zrun[g] = 0;
      end else begin
        was = active[g];
        dd  = done_due[g];
        check(nm(g, "busy"), s_busy[g], active[g]);
        check(nm(g, "done"), s_done[g], done_due[g]);
        if (!active[g]) begin
          check(nm(g, "idle_valid"), s_valid[g], 0);
          check(nm(g, "idle_sel"), s_sel[g], 3);
        end
        if (prev_stall[g]) begin
          check(nm(g, "stall_valid"), s_valid[g], 1);
          check(nm(g, "stall_data"), s_data[g], prev_data[g]);
        end
        if (active[g] && s_valid[g] && !prev_tv[g]) begin
          ez = (idx[g] == 0) ? 1 : (idx[g] >= 4) ? gap_of(g) : gap_of(g) + 1;
          check(nm(g, "idle_cycles_before_byte"), zrun[g], ez);
        end
        if (active[g] && !s_valid[g]) zrun[g]++;
        hs = active[g] && s_valid[g] && s_ready[g];
        prev_stall[g] = active[g] && s_valid[g] && !s_ready[g];
        prev_data[g]  = s_data[g];
        prev_tv[g]    = s_valid[g];
        if (hs) begin
          if (idx[g] < NB) check(nm(g, "byte"), s_data[g], expb[g][idx[g]]);
          else             check(nm(g, "byte_count"), idx[g] + 1, NB);
          es = (idx[g] < 4) ? 3 - idx[g] : 0;
          check(nm(g, "byte_sel"), s_sel[g], es);
          idx[g]++;
          zrun[g] = 0;
          if (idx[g] == NB) done_due[g] = 1;
        end
        if (dd) begin
          active[g] = 0; done_due[g] = 0; n_done[g]++;
        end
        if (!was && s_start[g]) begin
          active[g] = 1; idx[g] = 0; zrun[g] = 0; prev_tv[g] = 0;
          for (int i = 0; i < 4; i++) expb[g][i] = ch[i];
          expb[g][4] = ch[0] ^ ch[1] ^ ch[2] ^ ch[3];
        end
      end
    end
  endtask

  task automatic step();
    monitor();
    @(negedge clk);
  endtask

  task automatic run_wait(input string name, input int bound);
    int n = 0;
    while ((active[0] || active[1]) && n < bound) begin
      step();
      n++;
    end
    check(name, (active[0] || active[1]) ? 1 : 0, 0);
  endtask

  task automatic set_vec(input int i, input logic st, input logic rd, input logic [1:0] sl,
                         input logic tv, input logic [7:0] d, input logic bz, input logic dn);
    vec[i] = '{st, rd, sl, tv, d, bz, dn};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, d1, n, stall;
    n_cmp = 0; n_err = 0;
    for (int g = 0; g < 2; g++) begin
      s_start[g] = 0; s_ready[g] = 1; n_done[g] = 0;
      active[g] = 0; done_due[g] = 0; prev_stall[g] = 0; prev_tv[g] = 0;
      prev_data[g] = 0; idx[g] = 0; zrun[g] = 0;
    end
    ch[0] = 8'hA5; ch[1] = 8'h3C; ch[2] = 8'h0F; ch[3] = 8'hF0;

    // Expected per-cycle outputs of the no-gap instance, cycle 0 = start.
    set_vec(0,  1, 1, 2'b11, 0, 8'h00, 0, 0);
    set_vec(1,  0, 1, 2'b11, 0, 8'h00, 1, 0);
    set_vec(2,  0, 1, 2'b11, 1, 8'hA5, 1, 0);
    set_vec(3,  0, 1, 2'b10, 0, 8'hA5, 1, 0);
    set_vec(4,  1, 1, 2'b10, 1, 8'h3C, 1, 0);
    set_vec(5,  0, 1, 2'b01, 0, 8'h3C, 1, 0);
    set_vec(6,  0, 1, 2'b01, 1, 8'h0F, 1, 0);
    set_vec(7,  0, 1, 2'b00, 0, 8'h0F, 1, 0);
    set_vec(8,  0, 1, 2'b00, 1, 8'hF0, 1, 0);
`ifdef RESULT_BYTE_SEQ_CHECKSUM_EN
    set_vec(9,  0, 1, 2'b00, 1, 8'h66, 1, 0);
    set_vec(10, 1, 1, 2'b00, 0, 8'h66, 1, 1);
    set_vec(11, 0, 1, 2'b11, 0, 8'h66, 0, 0);
    set_vec(12, 0, 1, 2'b11, 0, 8'h66, 0, 0);
    nvec = 13;
`else
    set_vec(9,  1, 1, 2'b00, 0, 8'hF0, 1, 1);
    set_vec(10, 0, 1, 2'b11, 0, 8'hF0, 0, 0);
    set_vec(11, 0, 1, 2'b11, 0, 8'hF0, 0, 0);
    nvec = 12;
`endif

    rst = 1;
    repeat (3) step();
    rst = 0;
    for (int g = 0; g < 2; g++) begin
      check(nm(g, "reset_sel"), s_sel[g], 3);
      check(nm(g, "reset_data"), s_data[g], 0);
      check(nm(g, "reset_valid"), s_valid[g], 0);
      check(nm(g, "reset_busy"), s_busy[g], 0);
      check(nm(g, "reset_done"), s_done[g], 0);
    end

    // Directed latency table, including start while busy and on the done cycle.
    for (int i = 0; i < nvec; i++) begin
      s_start[0] = vec[i].start;
      s_ready[0] = vec[i].ready;
      check($sformatf("row%0d_sel", i), s_sel[0], vec[i].sel);
      check($sformatf("row%0d_valid", i), s_valid[0], vec[i].tv);
      check($sformatf("row%0d_data", i), s_data[0], vec[i].data);
      check($sformatf("row%0d_busy", i), s_busy[0], vec[i].busy);
      check($sformatf("row%0d_done", i), s_done[0], vec[i].done);
      step();
    end
    s_start[0] = 0;
    check("table_done_pulses", n_done[0], 1);

    // Five stall cycles on every byte.
    d0 = n_done[0];
    s_start[0] = 1; s_ready[0] = 0;
    step();
    s_start[0] = 0;
    stall = 0; n = 0;
    while (active[0] && n < 200) begin
      s_ready[0] = s_valid[0] && (stall == 5);
      if (s_valid[0] && !s_ready[0]) stall++;
      else if (s_valid[0]) stall = 0;
      step();
      n++;
    end
    s_ready[0] = 1;
    check("stall_done_pulses", n_done[0] - d0, 1);

    // Gap instance with the sink always ready.
    d1 = n_done[1];
    s_start[1] = 1;
    step();
    s_start[1] = 0;
    run_wait("gap_finished", 200);
    check("gap_done_pulses", n_done[1] - d1, 1);

    // Reset while the second byte is being offered.
    d0 = n_done[0];
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    repeat (3) step();
    check("pre_reset_valid", s_valid[0], 1);
    check("pre_reset_sel", s_sel[0], 2);
    rst = 1; s_ready[0] = 0;
    step();
    rst = 0; s_ready[0] = 1;
    check("post_reset_valid", s_valid[0], 0);
    check("post_reset_busy", s_busy[0], 0);
    check("post_reset_sel", s_sel[0], 3);
    check("post_reset_done", s_done[0], 0);
    step();
    check("reset_no_done", n_done[0] - d0, 0);
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    run_wait("restart_finished", 200);
    check("restart_done_pulses", n_done[0] - d0, 1);

    // Randomized data, back-pressure and ignored start pulses on both instances.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++) ch[i] = 8'($urandom_range(0, 255));
      d0 = n_done[0]; d1 = n_done[1];
      s_start[0] = 1; s_start[1] = 1;
      step();
      n = 0;
      while ((active[0] || active[1]) && n < 400) begin
        for (int g = 0; g < 2; g++) begin
          s_ready[g] = ($urandom_range(0, 3) != 0);
          s_start[g] = active[g] && ($urandom_range(0, 5) == 0);
        end
        step();
        n++;
      end
      s_start[0] = 0; s_start[1] = 0;
      s_ready[0] = 1; s_ready[1] = 1;
      check($sformatf("rand%0d_dut0_dones", it), n_done[0] - d0, 1);
      check($sformatf("rand%0d_dut1_dones", it), n_done[1] - d1, 1);
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_byte_sequencer.md
Name: result_byte_sequencer

Overview:
Drives the select lines of the result byte mux (4x1, 8-bit) to walk the four bytes of a 32-bit logarithm result. Each byte is pulled back from the mux output and forwarded to a byte-wide sink (UART TX / display driver) over a valid/ready handshake. It sits between the mux and the serial/display output in the verification environment and turns a one-cycle start into a complete 4-byte transfer.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after each accepted byte before fetching the next; 0 means no gap
GAP_W, 8, width of the gap counter; GAP_CYCLES must be less than 2**GAP_W

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
sel  output  2  select to mux; 2'b11 = ch_0 (MSB byte), 2'b10 = ch_1, 2'b01 = ch_2, 2'b00 = ch_3 (LSB byte)
byte_in  input  8  mux data_out for the current sel (combinational return path)
tx_data  output  8  byte presented to sink
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts when tx_valid && tx_ready
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset values: sel=2'b11, tx_data=8'h00, tx_valid=0, busy=0, done=0, gap counter=0, state=IDLE. Reset applies mid-transfer: tx_valid drops on the next edge and the transfer is abandoned. No done pulse is issued.
- States: IDLE, FETCH, SEND, GAP, CKSUM (feature only), FIN.
- IDLE: sel held at 2'b11. When start=1, go to FETCH and set busy=1.
- FETCH (1 cycle): tx_data <= byte_in (captured from the current registered sel). Set tx_valid<=1 and go to SEND.
- SEND: hold tx_valid=1 and tx_data stable until tx_valid && tx_ready. tx_valid must never drop without a handshake. On the handshake cycle:
  - tx_valid<=0.
  - If sel != 2'b00: sel<=sel-1, then go to GAP if GAP_CYCLES>0, else FETCH.
  - If sel == 2'b00: go to CKSUM (feature) or FIN.
- GAP: counter loads GAP_CYCLES-1 on entry and decrements. Go to FETCH when it reaches 0. This gives exactly GAP_CYCLES cycles in GAP.
- FIN (1 cycle): done=1, busy<=0, sel<=2'b11, then IDLE.
- Latency with tx_ready tied high and GAP_CYCLES=0:
  - start at cycle 0, first tx_valid at cycle 2.
  - One byte every 2 cycles.
  - done at cycle 9 (cycle 10 with checksum).
- start while busy is ignored, with no queueing. start in the same cycle as done is also ignored (the FSM is in FIN, not IDLE).
- sel changes only on a SEND handshake or in FIN, so byte_in is stable for at least one full cycle before FETCH samples it.
- tx_ready asserted while tx_valid=0 has no effect.

Optional Feature:
RESULT_BYTE_SEQ_CHECKSUM_EN
- Defined: an XOR accumulator (reset 8'h00, cleared on start acceptance) XORs each byte captured in FETCH. After the ch_3 handshake the FSM goes to CKSUM, which loads tx_data<=accumulator and tx_valid<=1. It then uses SEND handshake rules and goes to FIN on acceptance, giving 5 bytes per transfer. The GAP rule also applies before CKSUM.
- Undefined: no accumulator and no CKSUM state; exactly 4 bytes per transfer.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, SEND, GAP, CKSUM, FIN) as localparams;
  - SEL_FIRST=2'b11 and SEL_LAST=2'b00;
  - BYTE_W=8.
- One natural sub-module: result_byte_gap_timer (load/decrement counter with zero flag), reused by other output pacers.
- The FSM, sel register, and tx register stay in the top.

Test Plan:
- Bench mux ch_0=8'hA5, ch_1=8'h3C, ch_2=8'h0F, ch_3=8'hF0; tx_ready=1, GAP_CYCLES=0; pulse start -> tx_data sequence A5,3C,0F,F0; sel sequence 11,10,01,00; done at cycle 9; sel back to 11.
- Same data, tx_ready low for 5 cycles at each byte -> tx_valid held and tx_data stable throughout each stall; byte order unchanged; no byte lost or duplicated.
- GAP_CYCLES=3 -> exactly 3 cycles with tx_valid=0 between consecutive handshakes plus the FETCH cycle; done after byte 4.
- rst asserted while in SEND of byte 2 -> next cycle tx_valid=0, busy=0, sel=11, no done; a new start gives A5 first.
- start pulsed again while busy and on the done cycle -> ignored; exactly 4 handshakes and one done pulse.
- RESULT_BYTE_SEQ_CHECKSUM_EN defined -> 5th byte 8'h66 (A5^3C^0F^F0); done follows its handshake; second run gives 8'h66 again (accumulator cleared).
